// File: rtl/rs_group_scheduler.sv
// Collects RS codewords into four-word groups (A..D) for the lane distributor and tracks AM periods.
// Optional RS_SCHED_DOUBLE_BUFFER_EN: separate fill/output buffers so filling continues while a group waits.
module rs_group_scheduler #(
   parameter int WIDTH_WORD_RS    = 5440,
   parameter int AM_PERIOD_GROUPS = 2048
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [WIDTH_WORD_RS-1:0]            i_cw,
   input  logic                                i_cw_valid,
   output logic                                o_cw_ready,
   input  logic                                i_flush,
   output logic [WIDTH_WORD_RS-1:0]            o_word_A,
   output logic [WIDTH_WORD_RS-1:0]            o_word_B,
   output logic [WIDTH_WORD_RS-1:0]            o_word_C,
   output logic [WIDTH_WORD_RS-1:0]            o_word_D,
   output logic                                o_group_valid,
   input  logic                                i_group_ready,
   output logic                                o_am_sync,
   output logic [1:0]                          o_slot,
   output logic [$clog2(AM_PERIOD_GROUPS)-1:0] o_group_cnt
);

   localparam int CNT_W = $clog2(AM_PERIOD_GROUPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD_GROUPS - 1);

   typedef enum logic {FILL, STALL} state_t;

   state_t                   state, state_nxt;
   logic [1:0]               slot;
   logic                     group_valid;
   logic [CNT_W-1:0]         group_cnt;
   logic [WIDTH_WORD_RS-1:0] out_buf [4];
   logic                     accept, xfer, complete, load;

   assign o_cw_ready = (state == FILL);
   assign accept     = i_cw_valid && o_cw_ready;
   assign xfer       = group_valid && i_group_ready;
   // A flush in the completion cycle cancels the group.
   assign complete   = accept && (slot == 2'd3) && !i_flush;

`ifdef RS_SCHED_DOUBLE_BUFFER_EN
   logic [WIDTH_WORD_RS-1:0] fill_buf [4];

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         FILL: begin
            if (complete) begin
               if (!group_valid || xfer) load = 1'b1;
               else                      state_nxt = STALL;
            end
         end
         STALL: begin
            if (xfer) begin
               load      = 1'b1;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) fill_buf[slot] <= i_cw;
   end

   // A stalled group is already complete in fill_buf; otherwise slot D comes straight from i_cw.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) out_buf[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < 3; i++) out_buf[i] <= fill_buf[i];
         out_buf[3] <= (state == STALL) ? fill_buf[3] : i_cw;
      end
   end
`else
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         FILL: begin
            if (complete) begin
               load      = 1'b1;
               state_nxt = STALL;
            end
         end
         STALL: begin
            if (xfer) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // The single buffer is filled in place and presented directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) out_buf[i] <= '0;
      end else if (accept) begin
         out_buf[slot] <= i_cw;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         slot        <= 2'd0;
         group_valid <= 1'b0;
         group_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (i_flush)     slot <= 2'd0;
         else if (accept) slot <= slot + 2'd1;
         if (load)        group_valid <= 1'b1;
         else if (xfer)   group_valid <= 1'b0;
         if (xfer)        group_cnt <= (group_cnt == CNT_LAST) ? '0 : group_cnt + 1'b1;
      end
   end

   assign o_word_A      = out_buf[0];
   assign o_word_B      = out_buf[1];
   assign o_word_C      = out_buf[2];
   assign o_word_D      = out_buf[3];
   assign o_group_valid = group_valid;
   assign o_am_sync     = group_valid && (group_cnt == '0);
   assign o_slot        = slot;
   assign o_group_cnt   = group_cnt;

endmodule

// File: doc/rs_group_scheduler.md
# rs_group_scheduler

Sequences RS-encoded codewords into the 16-lane distribution stage. Codewords arrive one at a time from the RS encoder over a valid/ready handshake and are collected into four-codeword groups (A, B, C, D). Each group is presented to the lane distributor as one wide transfer. Groups are counted so that `o_am_sync` marks the first group of every alignment-marker period.

## Interface
Parameters:
- `WIDTH_WORD_RS`, 5440: codeword width in bits (544 symbols × 10 bits).
- `AM_PERIOD_GROUPS`, 2048: groups per alignment-marker period; legal range ≥2. Counter width is `$clog2(AM_PERIOD_GROUPS)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_cw`, in, `WIDTH_WORD_RS`: codeword from the RS encoder.
- `i_cw_valid`, in, 1: `i_cw` is valid.
- `o_cw_ready`, out, 1: the block can accept a codeword this cycle.
- `i_flush`, in, 1: discard the partially filled group.
- `o_word_A`, `o_word_B`, `o_word_C`, `o_word_D`, out, `WIDTH_WORD_RS` each: the group codewords in arrival order.
- `o_group_valid`, out, 1: the group on `o_word_*` is valid; this drives the distributor's `i_valid`.
- `i_group_ready`, in, 1: downstream accepts the group. Tie to 1 when driving the lane distributor directly.
- `o_am_sync`, out, 1: the current group is the first of an AM period.
- `o_slot`, out, 2: next fill slot (0 = A … 3 = D).
- `o_group_cnt`, out, `$clog2(AM_PERIOD_GROUPS)`: group index within the current AM period.

## Operation
- Codeword accept: `i_cw_valid && o_cw_ready`. The codeword is written to fill slot `o_slot`, then `o_slot` increments. It wraps 3 → 0 when the group completes.
- Group complete: the 4th accepted codeword (slot 3). The fill buffer moves to the output buffer, and `o_group_valid` is set.
- Output transfer: `o_group_valid && i_group_ready`.
  - On transfer, `o_group_cnt` increments and wraps `AM_PERIOD_GROUPS-1` → 0.
  - `o_word_*` and `o_group_valid` hold stable while valid and not ready.
- `o_am_sync` = `o_group_valid && (o_group_cnt == 0)`. The first group after reset carries `o_am_sync = 1`.
- Flush:
  - When `i_flush=1`, `o_slot` goes to 0 and the fill contents are dropped.
  - A codeword accepted in the same cycle is also dropped.
  - A group already in the output buffer is unaffected; `o_group_cnt` is unaffected.
- Fill FSM states:
  - `FILL`: slot 0..3, ready high.
  - `STALL`: group complete but the output buffer is occupied and not transferring; `o_cw_ready=0`.
  - `STALL` → `FILL` on the cycle the output transfer occurs; the pending group loads into the output buffer that edge.
- Reset mid-operation: all partial and pending groups are discarded; `o_group_cnt` returns to 0.

## Timing
- Reset values: `o_cw_ready=1`, `o_group_valid=0`, `o_am_sync=0`, `o_slot=0`, `o_group_cnt=0`, `o_word_A..D` all zeros.
- Latency: `o_group_valid` asserts the cycle after the 4th codeword is accepted. There is no combinational path from `i_cw` to `o_word_*`.
- `o_cw_ready` is registered-state only; it has no combinational dependency on `i_cw_valid`.
  - It may depend combinationally on `i_group_ready` only in the completion cycle (see Configuration).
- Simultaneous events:
  - Output transfer and group completion in the same cycle: the new group loads into the output buffer and `o_group_valid` stays 1 with no bubble.
  - Flush and completion in the same cycle: flush wins and no group is produced.

## Configuration
- `RS_SCHED_DOUBLE_BUFFER_EN` defined:
  - Separate fill and output buffers, so filling continues while a group waits downstream.
  - With `i_group_ready=1`, sustained throughput is 1 group per 4 cycles.
  - `STALL` is entered only when both buffers are full.
- `RS_SCHED_DOUBLE_BUFFER_EN` undefined:
  - A single buffer serves as both fill and output.
  - `o_cw_ready=0` from group completion until the cycle after the output transfer.
  - Sustained throughput is 1 group per 5 cycles with `i_group_ready=1`.

## Test plan
- Reset, then 4 back-to-back codewords 0x1, 0x2, 0x3, 0x4 with `i_group_ready=1`:
  - `o_word_A..D` = 1, 2, 3, 4; `o_group_valid` high one cycle after the 4th accept; `o_am_sync=1`; `o_group_cnt` becomes 1.
- Continuous valid stream of 40 codewords, `i_group_ready=1`:
  - Double-buffer build: 10 groups in 40+1 cycles with no `o_cw_ready` deassertion.
  - Single-buffer build: 10 groups with ready low 1 cycle per group.
- `i_group_ready=0` for 12 cycles while streaming:
  - `o_word_*` stays stable.
  - Double-buffer build: `o_cw_ready` falls after 8 accepts; single-buffer build: after 4.
  - After ready rises, groups emerge in order with no loss or duplication.
- Accept 2 codewords, pulse `i_flush` together with a 3rd, then send 4 more (0xA..0xD):
  - Exactly one group, with `o_word_A..D` = A, B, C, D.
- `AM_PERIOD_GROUPS=4`, 9 groups transferred:
  - `o_am_sync` high on groups 0, 4 and 8 only; `o_group_cnt` wraps 3 → 0.
- Assert `rst` with one group pending and slot=2:
  - All outputs return to reset values next cycle; the next group after reset has `o_am_sync=1`.
